// File: rtl/p_hardisc.sv
// Shared types for the iterative multiply/divide unit: FSM states and RISC-V M funct3 codes.
package p_hardisc;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } mdu_state_t;

  localparam logic [2:0] FN_MUL    = 3'd0;
  localparam logic [2:0] FN_MULH   = 3'd1;
  localparam logic [2:0] FN_MULHSU = 3'd2;
  localparam logic [2:0] FN_MULHU  = 3'd3;
  localparam logic [2:0] FN_DIV    = 3'd4;
  localparam logic [2:0] FN_DIVU   = 3'd5;
  localparam logic [2:0] FN_REM    = 3'd6;
  localparam logic [2:0] FN_REMU   = 3'd7;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration on magnitudes: MUL_BPC shift-add partial products,
// and one restoring subtract/shift step. The caller decides which results to keep.
module muldiv_step #(
  parameter int XLEN    = 32,
  parameter int MUL_BPC = 2
) (
  input  logic [2*XLEN-1:0] i_acc,
  input  logic [2*XLEN-1:0] i_mcand,
  input  logic [XLEN-1:0]   i_mplier,
  input  logic [XLEN-1:0]   i_rem,
  input  logic [XLEN-1:0]   i_quo,
  input  logic [XLEN-1:0]   i_divisor,
  output logic [2*XLEN-1:0] o_acc,
  output logic [2*XLEN-1:0] o_mcand,
  output logic [XLEN-1:0]   o_mplier,
  output logic [XLEN-1:0]   o_rem,
  output logic [XLEN-1:0]   o_quo
);

  logic [XLEN:0]   w_shift;
  logic [XLEN-1:0] w_diff;
  logic            w_fits;

  always_comb begin
    o_acc = i_acc;
    for (int k = 0; k < MUL_BPC; k++) begin
      if (i_mplier[k]) o_acc = o_acc + (i_mcand << k);
    end
  end

  assign o_mcand  = i_mcand << MUL_BPC;
  assign o_mplier = i_mplier >> MUL_BPC;

  // When the trial subtract fits, the difference is below the divisor, so XLEN bits suffice.
  assign w_shift = {i_rem, i_quo[XLEN-1]};
  assign w_fits  = (w_shift >= {1'b0, i_divisor});
  assign w_diff  = w_shift[XLEN-1:0] - i_divisor;
  assign o_rem   = w_fits ? w_diff : w_shift[XLEN-1:0];
  assign o_quo   = {i_quo[XLEN-2:0], w_fits};

endmodule

// File: rtl/muldiv_iter.sv
// Iterative RISC-V M-extension unit: shift-add multiply, restoring divide, sign fix-up at the end.
// Optional MDU_FAST_ZERO_EN: zero-operand multiplies and divide-by-zero/overflow finish in one cycle.
module muldiv_iter
  import p_hardisc::*;
#(
  parameter int XLEN    = 32,
  parameter int MUL_BPC = 2
) (
  input  logic            s_clk_i,
  input  logic            s_reset_i,
  input  logic            s_stall_i,
  input  logic            s_flush_i,
  input  logic            s_start_i,
  input  logic [2:0]      s_function_i,
  input  logic [XLEN-1:0] s_operand1_i,
  input  logic [XLEN-1:0] s_operand2_i,
  output logic            s_busy_o,
  output logic            s_finished_o,
  output logic [XLEN-1:0] s_result_o
);

  localparam int MUL_CYC = XLEN / MUL_BPC;
  localparam int CW      = $clog2(XLEN) + 1;

  mdu_state_t        r_state, w_state_n;
  logic [CW-1:0]     r_cnt;
  logic [2:0]        r_fn;
  logic [2*XLEN-1:0] r_acc, r_mcand, w_acc_n, w_mcand_n, w_prod;
  logic [XLEN-1:0]   r_mplier, r_rem, r_quo, r_divisor, r_op1;
  logic [XLEN-1:0]   w_mplier_n, w_rem_n, w_quo_n, w_abs1, w_abs2, w_qfix, w_rfix, w_res;
  logic              r_neg1, r_neg2, r_dz, r_ovf;
  logic              w_sgn1, w_sgn2, w_neg1, w_neg2, w_dz, w_ovf, w_fast, w_go;

  assign w_sgn1 = (s_function_i == FN_MULH) || (s_function_i == FN_MULHSU) ||
                  (s_function_i == FN_DIV)  || (s_function_i == FN_REM);
  assign w_sgn2 = (s_function_i == FN_MULH) || (s_function_i == FN_DIV) ||
                  (s_function_i == FN_REM);
  assign w_neg1 = w_sgn1 & s_operand1_i[XLEN-1];
  assign w_neg2 = w_sgn2 & s_operand2_i[XLEN-1];
  assign w_abs1 = w_neg1 ? -s_operand1_i : s_operand1_i;
  assign w_abs2 = w_neg2 ? -s_operand2_i : s_operand2_i;
  assign w_dz   = (s_operand2_i == '0);
  assign w_ovf  = ((s_function_i == FN_DIV) || (s_function_i == FN_REM)) &&
                  (s_operand1_i == {1'b1, {(XLEN-1){1'b0}}}) && (s_operand2_i == '1);
  assign w_go   = (r_state == IDLE) && s_start_i && !s_flush_i;

`ifdef MDU_FAST_ZERO_EN
  assign w_fast = s_function_i[2] ? (w_dz | w_ovf)
                                  : ((s_operand1_i == '0) || (s_operand2_i == '0));
`else
  assign w_fast = 1'b0;
`endif

  always_comb begin
    w_state_n = r_state;
    unique case (r_state)
      IDLE:     if (s_start_i) w_state_n = w_fast ? DONE : (s_function_i[2] ? DIV : MUL);
      MUL, DIV: if (r_cnt == '0) w_state_n = DONE;
      DONE:     if (!s_stall_i) w_state_n = IDLE;
      default:  w_state_n = IDLE;
    endcase
    if (s_flush_i) w_state_n = IDLE;
  end

  muldiv_step #(.XLEN(XLEN), .MUL_BPC(MUL_BPC)) u_step (
    .i_acc     (r_acc),
    .i_mcand   (r_mcand),
    .i_mplier  (r_mplier),
    .i_rem     (r_rem),
    .i_quo     (r_quo),
    .i_divisor (r_divisor),
    .o_acc     (w_acc_n),
    .o_mcand   (w_mcand_n),
    .o_mplier  (w_mplier_n),
    .o_rem     (w_rem_n),
    .o_quo     (w_quo_n)
  );

  always_ff @(posedge s_clk_i) begin
    if (s_reset_i) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_fn      <= '0;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_divisor <= '0;
      r_op1     <= '0;
      r_neg1    <= 1'b0;
      r_neg2    <= 1'b0;
      r_dz      <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_state <= w_state_n;
      if (w_go) begin
        r_fn      <= s_function_i;
        r_op1     <= s_operand1_i;
        r_neg1    <= w_neg1;
        r_neg2    <= w_neg2;
        r_dz      <= s_function_i[2] & w_dz;
        r_ovf     <= w_ovf;
        r_acc     <= '0;
        r_mcand   <= {{XLEN{1'b0}}, w_abs1};
        r_mplier  <= w_abs2;
        r_rem     <= '0;
        r_quo     <= w_abs1;
        r_divisor <= w_abs2;
        r_cnt     <= s_function_i[2] ? CW'(XLEN - 1) : CW'(MUL_CYC - 1);
      end else if (r_state == MUL) begin
        r_acc    <= w_acc_n;
        r_mcand  <= w_mcand_n;
        r_mplier <= w_mplier_n;
        r_cnt    <= r_cnt - 1'b1;
      end else if (r_state == DIV) begin
        r_rem <= w_rem_n;
        r_quo <= w_quo_n;
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  // Special cases override the magnitude path so the fast path needs no iterations.
  assign w_prod = (r_neg1 ^ r_neg2) ? -r_acc : r_acc;
  assign w_qfix = r_dz ? '1 : (r_ovf ? r_op1 : ((r_neg1 ^ r_neg2) ? -r_quo : r_quo));
  assign w_rfix = r_dz ? r_op1 : (r_ovf ? '0 : (r_neg1 ? -r_rem : r_rem));

  always_comb begin
    w_res = '0;
    unique case (r_fn)
      FN_MUL:                       w_res = w_prod[XLEN-1:0];
      FN_MULH, FN_MULHSU, FN_MULHU: w_res = w_prod[2*XLEN-1:XLEN];
      FN_DIV, FN_DIVU:              w_res = w_qfix;
      default:                      w_res = w_rfix;
    endcase
  end

  assign s_busy_o     = (r_state == MUL) || (r_state == DIV);
  assign s_finished_o = (r_state == DONE);
  assign s_result_o   = (r_state == DONE) ? w_res : '0;

endmodule

// File: tb/tb_muldiv_iter.sv
// Directed self-checking bench for muldiv_iter at XLEN=32, MUL_BPC=2.
module tb_muldiv_iter;
  import p_hardisc::*;

`ifdef MDU_FAST_ZERO_EN
  localparam int LAT_MZ = 1;
  localparam int LAT_DZ = 1;
`else
  localparam int LAT_MZ = 17;
  localparam int LAT_DZ = 33;
`endif

  logic        clk, s_reset, s_stall, s_flush, s_start;
  logic [2:0]  s_function;
  logic [31:0] s_op1, s_op2;
  logic        s_busy, s_finished;
  logic [31:0] s_result;
  int          total, bad;

  muldiv_iter #(.XLEN(32), .MUL_BPC(2)) dut (
    .s_clk_i      (clk),
    .s_reset_i    (s_reset),
    .s_stall_i    (s_stall),
    .s_flush_i    (s_flush),
    .s_start_i    (s_start),
    .s_function_i (s_function),
    .s_operand1_i (s_op1),
    .s_operand2_i (s_op2),
    .s_busy_o     (s_busy),
    .s_finished_o (s_finished),
    .s_result_o   (s_result)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Called at a negedge; drives start and counts negedges until finished (-1 on timeout).
  task automatic run_op(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
    s_function = fn; s_op1 = a; s_op2 = b; s_start = 1'b1;
    lat = -1; res = '0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (s_finished) begin lat = c; res = s_result; break; end
    end
    s_start = 1'b0;
  endtask

  task automatic test_reset();
    s_reset = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (s_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", s_busy); end
    total++; if (s_finished !== 1'b0) begin bad++; $display("FAIL reset_fin got=%0b want=0", s_finished); end
    total++; if (s_result !== 32'h0) begin bad++; $display("FAIL reset_result got=%h want=0", s_result); end
    s_reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mul();
    logic [2:0]  fn_t [8] = '{FN_MUL, FN_MULHU, FN_MULHSU, FN_MULH, FN_MULH, FN_MULHU, FN_MUL, FN_MULHSU};
    logic [31:0] a_t  [8] = '{32'h7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h80000000, 32'h80000000, 32'h12345678, 32'h80000000};
    logic [31:0] b_t  [8] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h3, 32'h80000000, 32'h4, 32'h10, 32'h2};
    logic [31:0] e_t  [8] = '{32'hFFFFFFEB, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h40000000, 32'h2, 32'h23456780, 32'hFFFFFFFF};
    logic [31:0] res;
    int lat;
    for (int i = 0; i < 8; i++) begin
      run_op(fn_t[i], a_t[i], b_t[i], res, lat);
      total++; if (res !== e_t[i]) begin bad++; $display("FAIL mul_result[%0d] got=%h want=%h", i, res, e_t[i]); end
      total++; if (lat != 17) begin bad++; $display("FAIL mul_latency[%0d] got=%0d want=17", i, lat); end
      @(negedge clk);
    end
  endtask

  task automatic test_div();
    logic [2:0]  fn_t [8] = '{FN_DIV, FN_REM, FN_DIVU, FN_REMU, FN_DIV, FN_REM, FN_DIVU, FN_REMU};
    logic [31:0] a_t  [8] = '{32'hFFFFFFEC, 32'hFFFFFFEC, 32'd100, 32'd100, 32'd20, 32'd20, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] b_t  [8] = '{32'd3, 32'd3, 32'd7, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'h10, 32'h10};
    logic [31:0] e_t  [8] = '{32'hFFFFFFFA, 32'hFFFFFFFE, 32'd14, 32'd2, 32'hFFFFFFFA, 32'd2, 32'h0FFFFFFF, 32'hF};
    logic [31:0] res;
    int lat;
    for (int i = 0; i < 8; i++) begin
      run_op(fn_t[i], a_t[i], b_t[i], res, lat);
      total++; if (res !== e_t[i]) begin bad++; $display("FAIL div_result[%0d] got=%h want=%h", i, res, e_t[i]); end
      total++; if (lat != 33) begin bad++; $display("FAIL div_latency[%0d] got=%0d want=33", i, lat); end
      @(negedge clk);
    end
  endtask

  task automatic test_corner();
    logic [2:0]  fn_t [9] = '{FN_DIVU, FN_REM, FN_DIV, FN_DIV, FN_REM, FN_REMU, FN_MUL, FN_MULHU, FN_DIVU};
    logic [31:0] a_t  [9] = '{32'd5, 32'h80000000, 32'h80000000, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'd5, 32'h0, 32'd5, 32'h0};
    logic [31:0] b_t  [9] = '{32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0, 32'h7B, 32'h0, 32'd5};
    logic [31:0] e_t  [9] = '{32'hFFFFFFFF, 32'h0, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'd5, 32'h0, 32'h0, 32'h0};
    int          l_t  [9] = '{LAT_DZ, LAT_DZ, LAT_DZ, LAT_DZ, LAT_DZ, LAT_DZ, LAT_MZ, LAT_MZ, 33};
    logic [31:0] res;
    int lat;
    for (int i = 0; i < 9; i++) begin
      run_op(fn_t[i], a_t[i], b_t[i], res, lat);
      total++; if (res !== e_t[i]) begin bad++; $display("FAIL corner_result[%0d] got=%h want=%h", i, res, e_t[i]); end
      total++; if (lat != l_t[i]) begin bad++; $display("FAIL corner_latency[%0d] got=%0d want=%0d", i, lat, l_t[i]); end
      @(negedge clk);
    end
  endtask

  task automatic test_stall();
    logic [31:0] res;
    int lat;
    s_stall = 1'b1;
    run_op(FN_DIVU, 32'd100, 32'd7, res, lat);
    total++; if (res !== 32'd14) begin bad++; $display("FAIL stall_first got=%h want=%h", res, 32'd14); end
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      total++; if (s_finished !== 1'b1) begin bad++; $display("FAIL stall_fin[%0d] got=%0b want=1", k, s_finished); end
      total++; if (s_result !== 32'd14) begin bad++; $display("FAIL stall_hold[%0d] got=%h want=%h", k, s_result, 32'd14); end
    end
    s_stall = 1'b0;
    @(negedge clk);
    total++; if (s_finished !== 1'b0) begin bad++; $display("FAIL stall_release got=%0b want=0", s_finished); end
    total++; if (s_result !== 32'h0) begin bad++; $display("FAIL stall_release_res got=%h want=0", s_result); end
  endtask

  task automatic test_flush();
    int seen;
    s_function = FN_DIV; s_op1 = 32'd1000; s_op2 = 32'd3; s_start = 1'b1;
    repeat (10) @(negedge clk);
    total++; if (s_busy !== 1'b1) begin bad++; $display("FAIL flush_busy_before got=%0b want=1", s_busy); end
    s_flush = 1'b1; s_start = 1'b0;
    @(negedge clk);
    s_flush = 1'b0;
    total++; if (s_busy !== 1'b0) begin bad++; $display("FAIL flush_busy_after got=%0b want=0", s_busy); end
    total++; if (s_finished !== 1'b0) begin bad++; $display("FAIL flush_fin_after got=%0b want=0", s_finished); end
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (s_finished || s_busy) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL flush_no_finish got=%0d want=0", seen); end
    s_function = FN_MUL; s_op1 = 32'd3; s_op2 = 32'd3; s_start = 1'b1; s_flush = 1'b1;
    @(negedge clk);
    total++; if (s_busy !== 1'b0) begin bad++; $display("FAIL flush_beats_start got=%0b want=0", s_busy); end
    s_start = 1'b0; s_flush = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [31:0] res;
    int lat;
    s_function = FN_MUL; s_op1 = 32'd9; s_op2 = 32'd9; s_start = 1'b1;
    repeat (5) @(negedge clk);
    s_reset = 1'b1; s_start = 1'b0;
    @(negedge clk);
    s_reset = 1'b0;
    total++; if (s_busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%0b want=0", s_busy); end
    total++; if (s_finished !== 1'b0) begin bad++; $display("FAIL rstmid_fin got=%0b want=0", s_finished); end
    total++; if (s_result !== 32'h0) begin bad++; $display("FAIL rstmid_result got=%h want=0", s_result); end
    run_op(FN_MUL, 32'd3, 32'd4, res, lat);
    total++; if (res !== 32'd12) begin bad++; $display("FAIL rstmid_mul got=%h want=%h", res, 32'd12); end
    total++; if (lat != 17) begin bad++; $display("FAIL rstmid_latency got=%0d want=17", lat); end
    @(negedge clk);
  endtask

  // Start stays high through DONE: the unit must pass through IDLE before restarting.
  task automatic test_back_to_back();
    int lat;
    logic [31:0] res;
    s_function = FN_MUL; s_op1 = 32'd6; s_op2 = 32'd7; s_start = 1'b1;
    for (int pass = 0; pass < 2; pass++) begin
      lat = -1; res = '0;
      for (int c = 1; c <= 200; c++) begin
        @(negedge clk);
        if (s_finished) begin lat = c; res = s_result; break; end
      end
      total++; if (res !== 32'd42) begin bad++; $display("FAIL b2b_result[%0d] got=%h want=%h", pass, res, 32'd42); end
      total++; if (lat != 17) begin bad++; $display("FAIL b2b_latency[%0d] got=%0d want=17", pass, lat); end
      @(negedge clk);
      total++; if (s_busy !== 1'b0 || s_finished !== 1'b0) begin
        bad++; $display("FAIL b2b_idle_gap[%0d] got busy=%0b fin=%0b want 0/0", pass, s_busy, s_finished);
      end
    end
    s_start = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  initial begin
    total = 0; bad = 0;
    s_reset = 1'b1; s_stall = 1'b0; s_flush = 1'b0; s_start = 1'b0;
    s_function = '0; s_op1 = '0; s_op2 = '0;
    @(negedge clk);
    test_reset();
    test_mul();
    test_div();
    test_corner();
    test_stall();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_iter.md
MULDIV_ITER -- requirements
Module: muldiv_iter

Interface
REQ-001 The module SHALL have parameter XLEN, default 32: operand and result width; legal values 16, 32 or 64.
REQ-002 The module SHALL have parameter MUL_BPC, default 2: multiplier bits retired per cycle; legal values 1, 2, 4 or 8, dividing XLEN.
REQ-003 The module SHALL have port s_clk_i, input, 1 bit: clock, rising edge.
REQ-004 The module SHALL have port s_reset_i, input, 1 bit: synchronous, active-high reset.
REQ-005 The module SHALL have port s_stall_i, input, 1 bit: downstream stall; holds a completed result.
REQ-006 The module SHALL have port s_flush_i, input, 1 bit: abort the current operation.
REQ-007 The module SHALL have port s_start_i, input, 1 bit: an MDU instruction occupies the stage; held high until it leaves.
REQ-008 The module SHALL have port s_function_i, input, 3 bits: RISC-V M funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
REQ-009 The module SHALL have ports s_operand1_i and s_operand2_i, inputs, XLEN bits each: rs1 and rs2.
REQ-010 The module SHALL have port s_busy_o, output, 1 bit: iteration in progress.
REQ-011 The module SHALL have port s_finished_o, output, 1 bit: s_result_o is valid.
REQ-012 The module SHALL have port s_result_o, output, XLEN bits: result.

Function
REQ-013 The FSM SHALL have states IDLE, MUL, DIV and DONE.
REQ-014 In IDLE with s_start_i=1 and s_flush_i=0, the module SHALL latch the operands, absolute values and sign flags, and enter MUL or DIV according to funct3[2].
REQ-015 MUL SHALL last XLEN/MUL_BPC cycles using shift-add, then go to DONE; s_finished_o SHALL rise XLEN/MUL_BPC+1 cycles after the start cycle.
REQ-016 DIV SHALL perform restoring division for XLEN cycles at 1 bit per cycle, then go to DONE; s_finished_o SHALL rise XLEN+1 cycles after the start cycle.
REQ-017 s_busy_o SHALL equal (state==MUL || state==DIV), and s_finished_o SHALL equal (state==DONE).
REQ-018 In DONE, s_result_o and s_finished_o SHALL be held while s_stall_i=1; with s_stall_i=0 the next state SHALL be IDLE.
REQ-019 A new operation SHALL never start in the cycle DONE is left; s_start_i is sampled only in IDLE.
REQ-020 s_flush_i=1 in any state SHALL force IDLE on the next edge, with no s_finished_o pulse; flush wins over a simultaneous start.
REQ-021 Signed results SHALL be produced by magnitude computation plus final two's-complement correction; MULHSU SHALL treat only rs1 as signed.
REQ-022 MUL SHALL return product[XLEN-1:0]; MULH, MULHSU and MULHU SHALL return product[2*XLEN-1:XLEN].
REQ-023 Division by zero SHALL give quotient all-ones (DIV and DIVU) and remainder = rs1.
REQ-024 Signed overflow (rs1=most-negative, rs2=-1) SHALL give DIV = most-negative and REM = 0.
REQ-025 s_result_o SHALL be 0 whenever the state is not DONE.

Reset
REQ-026 With s_reset_i=1 at a clock edge, state SHALL become IDLE, all datapath registers 0, and s_busy_o, s_finished_o and s_result_o 0.
REQ-027 Reset mid-operation SHALL discard the operation with no s_finished_o pulse; s_reset_i SHALL take priority over s_flush_i and s_start_i.

Configuration
REQ-028 With macro MDU_FAST_ZERO_EN defined, a multiply with either operand 0, or any division with rs2=0 or signed overflow, SHALL go from IDLE directly to DONE, so s_finished_o rises 1 cycle after the start cycle.
REQ-029 With MDU_FAST_ZERO_EN undefined, these cases SHALL use the full latency of REQ-015/REQ-016 and SHALL give identical result values.

Structure
REQ-030 The state typedef and the funct3 encoding constants SHALL belong in package p_hardisc.
REQ-031 One combinational sub-module, muldiv_step, SHALL implement one iteration: MUL_BPC partial-product adds, or one restoring subtract/shift.
REQ-032 The RTL SHALL be 120-400 lines in total.

Verification
REQ-033 With XLEN=32 and MUL_BPC=2, MUL of 7 by -3 SHALL give s_result_o=0xFFFFFFEB, with s_finished_o high in cycle 17 after start.
REQ-034 MULHU of 0xFFFFFFFF by 0xFFFFFFFF SHALL give 0xFFFFFFFE; MULHSU of -1 by 0xFFFFFFFF SHALL give 0xFFFFFFFF.
REQ-035 DIV of -20 by 3 SHALL give 0xFFFFFFFA and REM of -20 by 3 SHALL give 0xFFFFFFFE, each finishing in cycle 33.
REQ-036 DIVU of 5 by 0 SHALL give 0xFFFFFFFF; REM of 0x80000000 by -1 SHALL give 0; each SHALL finish in cycle 1 with MDU_FAST_ZERO_EN defined and cycle 33 without.
REQ-037 A DONE result held under 3 stall cycles SHALL keep s_result_o stable; a flush in DIV cycle 10 SHALL give no s_finished_o, and the unit SHALL return to IDLE the next cycle.
REQ-038 s_reset_i asserted in MUL cycle 5 SHALL return all outputs to 0 next cycle; a following MUL of 3 by 4 SHALL give 12.
